// File: rtl/run_controller.sv
// -----------------------------------------------------------------------------
// run_controller
//
// Upstream sequencer for the processor top level. On a host request it holds
// the core in reset, releases it, counts execution cycles and ends the run on
// a core halt or when the cycle budget runs out. It owns the req/done
// start-finish handshake with the host.
//
// Ports:
//   clk          in   system clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset
//   req          in   host start request (level, 4-phase handshake)
//   core_halt    in   halt indication from the core's control unit
//   core_reset   out  synchronous reset driven to the core
//   core_run     out  high while the core is executing
//   busy         out  high from request acceptance until done asserts
//   done         out  run finished (halt or timeout), held until req drops
//   timeout      out  run ended by budget expiry, valid while done=1
//   cycle_count  out  execution cycles of the current/last run
// -----------------------------------------------------------------------------
module run_controller #(
  parameter int               CNT_W      = 16,
  parameter int               RST_CYCLES = 2,
  parameter logic [CNT_W-1:0] MAX_CYCLES = 16'd60000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             core_halt,
  output logic             core_reset,
  output logic             core_run,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  // Wide enough to hold the value RST_CYCLES itself.
  localparam int               RCW         = $clog2(RST_CYCLES + 1);
  localparam logic [RCW-1:0]   RST_LAST    = RCW'(RST_CYCLES);
  localparam logic [CNT_W-1:0] BUDGET_LAST = MAX_CYCLES - CNT_W'(1);

  state_t           state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             timeout_q, timeout_d;
  logic             core_reset_q, core_reset_d;
  logic             core_run_q, core_run_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and next-output logic. Outputs are decoded from the next state
  // and registered, so they change on the same edge as the state and no input
  // reaches an output without passing through a flop.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // the block leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d       = S_RST;
          rst_cnt_d     = '0;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end

      // The acceptance cycle is followed by RST_CYCLES counted cycles, so the
      // core leaves reset on the edge t+1+RST_CYCLES after req was sampled at t.
      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end

      // The halting cycle is counted too. Halt is checked first so that a halt
      // coinciding with budget expiry is reported as a normal completion.
      S_RUN: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        if (core_halt) begin
          state_d = S_DONE;
        end else if (cycle_count_q == BUDGET_LAST) begin
          state_d   = S_TIMEOUT;
          timeout_d = 1'b1;
        end
      end

      // req held high after completion must not retrigger: wait for it to drop.
      S_DONE, S_TIMEOUT: begin
        if (!req) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    core_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
    core_run_d   = (state_d == S_RUN);
    busy_d       = (state_d == S_RST) || (state_d == S_RUN);
    done_d       = (state_d == S_DONE) || (state_d == S_TIMEOUT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      core_reset_q  <= 1'b1;
      core_run_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      core_reset_q  <= core_reset_d;
      core_run_q    <= core_run_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign core_run    = core_run_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule
